// File: rtl/piece_drop_ctrl.sv
// Falling four-block bar controller: spawns a piece, queues player and gravity requests,
// validates each candidate position against the playfield and an external collision check.
module piece_drop_ctrl #(
    parameter int unsigned SIZE       = 16,
    parameter logic [9:0]  SPAWN_X    = 10'd272,
    parameter logic [9:0]  SPAWN_Y    = 10'd0,
    parameter logic [9:0]  X_MIN      = 10'd240,
    parameter logic [9:0]  X_MAX      = 10'd400,
    parameter logic [9:0]  Y_MAX      = 10'd464,
    parameter int unsigned FALL_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       rotate,
    input  logic       drop,
    output logic [9:0] ref_x,
    output logic [9:0] ref_y,
    output logic       vert,
    output logic       chk_req,
    output logic [9:0] chk_x,
    output logic [9:0] chk_y,
    output logic       chk_vert,
    input  logic       chk_ack,
    input  logic       chk_hit,
    output logic       active,
    output logic       locked,
    output logic       game_over
);

    typedef enum logic [2:0] {IDLE, SPAWN, WAIT, CHECK, COMMIT, LOCK} state_t;
    typedef enum logic [2:0] {OP_SPAWN, OP_ROT, OP_LEFT, OP_RIGHT, OP_FALL} op_t;

    localparam logic signed [10:0] STEP  = 11'(SIZE);
    localparam logic [11:0]        SPAN1 = 12'(SIZE);
    localparam logic [11:0]        SPAN4 = 12'(4 * SIZE);
    localparam logic [7:0]         FALL_LAST = 8'(FALL_TICKS - 1);

    state_t state, state_next;
    op_t    op, sel_op;

    logic [7:0]         fall_cnt;
    logic               p_rot, p_left, p_right, p_fall, drop_mode;
    logic               fall_want;
    logic               load_chk;
    logic               clr_rot, clr_left, clr_right, clr_fall;
    logic signed [10:0] cand_x, cand_y;
    logic               cand_vert;
    logic               ack_seen;
    logic               fall_wrap;

    // A candidate is legal only if the whole bar, in its orientation, lies inside the field.
    function automatic logic in_bounds(input logic signed [10:0] x,
                                       input logic signed [10:0] y,
                                       input logic               v);
        logic [11:0] ux;
        logic [11:0] uy;
        logic        ok;
        ux = {1'b0, x};
        uy = {1'b0, y};
        if (x[10] || y[10] || (ux < {2'b00, X_MIN}))
            ok = 1'b0;
        else if (v)
            ok = ((ux + SPAN1) <= {2'b00, X_MAX}) && ((uy + SPAN4) <= {2'b00, Y_MAX});
        else
            ok = ((ux + SPAN4) <= {2'b00, X_MAX}) && ((uy + SPAN1) <= {2'b00, Y_MAX});
        return ok;
    endfunction

    assign fall_want = p_fall || drop_mode;
    assign ack_seen  = chk_req && chk_ack;
    assign fall_wrap = active && frame_tick && (fall_cnt == FALL_LAST);
    assign locked    = (state == LOCK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        sel_op     = OP_FALL;
        cand_x     = $signed({1'b0, ref_x});
        cand_y     = $signed({1'b0, ref_y});
        cand_vert  = vert;
        load_chk   = 1'b0;
        clr_rot    = 1'b0;
        clr_left   = 1'b0;
        clr_right  = 1'b0;
        clr_fall   = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = SPAWN;
            end
            SPAWN: begin
                sel_op     = OP_SPAWN;
                cand_x     = $signed({1'b0, SPAWN_X});
                cand_y     = $signed({1'b0, SPAWN_Y});
                cand_vert  = 1'b0;
                load_chk   = 1'b1;
                state_next = CHECK;
            end
            WAIT: begin
                if (p_rot || p_left || p_right || fall_want) begin
                    if (p_rot) begin
                        sel_op    = OP_ROT;
                        clr_rot   = 1'b1;
                        cand_vert = !vert;
                        if (vert) begin
                            cand_x = $signed({1'b0, ref_x}) - STEP;
                            cand_y = $signed({1'b0, ref_y}) + STEP;
                        end else begin
                            cand_x = $signed({1'b0, ref_x}) + STEP;
                            cand_y = $signed({1'b0, ref_y}) - STEP;
                        end
                    end else if (p_left) begin
                        sel_op   = OP_LEFT;
                        clr_left = 1'b1;
                        cand_x   = $signed({1'b0, ref_x}) - STEP;
                    end else if (p_right) begin
                        sel_op    = OP_RIGHT;
                        clr_right = 1'b1;
                        cand_x    = $signed({1'b0, ref_x}) + STEP;
                    end else begin
                        sel_op   = OP_FALL;
                        clr_fall = 1'b1;
                        cand_y   = $signed({1'b0, ref_y}) + STEP;
                    end
                    // Illegal moves are silently dropped; an illegal fall means the piece has landed.
                    if (in_bounds(cand_x, cand_y, cand_vert)) begin
                        load_chk   = 1'b1;
                        state_next = CHECK;
                    end else if (sel_op == OP_FALL) begin
                        state_next = LOCK;
                    end
                end
            end
            CHECK: begin
                if (ack_seen) begin
                    if (!chk_hit)
                        state_next = COMMIT;
                    else if (op == OP_FALL)
                        state_next = LOCK;
                    else if (op == OP_SPAWN)
                        state_next = IDLE;
                    else
                        state_next = WAIT;
                end
            end
            COMMIT: state_next = WAIT;
            LOCK:   state_next = SPAWN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_x     <= SPAWN_X;
            ref_y     <= SPAWN_Y;
            vert      <= 1'b0;
            active    <= 1'b0;
            chk_req   <= 1'b0;
            chk_x     <= '0;
            chk_y     <= '0;
            chk_vert  <= 1'b0;
            op        <= OP_SPAWN;
            game_over <= 1'b0;
            fall_cnt  <= '0;
        end else begin
            game_over <= 1'b0;
            if (load_chk) begin
                chk_req  <= 1'b1;
                chk_x    <= cand_x[9:0];
                chk_y    <= cand_y[9:0];
                chk_vert <= cand_vert;
                op       <= sel_op;
            end else if (ack_seen) begin
                chk_req <= 1'b0;
            end
            if ((state == CHECK) && ack_seen && chk_hit && (op == OP_SPAWN))
                game_over <= 1'b1;
            if (state == COMMIT) begin
                ref_x <= chk_x;
                ref_y <= chk_y;
                vert  <= chk_vert;
                if (op == OP_SPAWN)
                    active <= 1'b1;
            end
            if (state_next == LOCK || state_next == IDLE)
                active <= 1'b0;
            if ((state == LOCK) || ((state == COMMIT) && (op == OP_SPAWN)))
                fall_cnt <= '0;
            else if (active && frame_tick)
                fall_cnt <= fall_wrap ? 8'd0 : fall_cnt + 8'd1;
        end
    end

    // A new pulse always wins over the clear of the same cycle so no request is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_rot     <= 1'b0;
            p_left    <= 1'b0;
            p_right   <= 1'b0;
            p_fall    <= 1'b0;
            drop_mode <= 1'b0;
        end else begin
            p_rot     <= (rotate && state != IDLE) ||
                         (p_rot && !clr_rot && state != LOCK && state != IDLE);
            p_left    <= (move_left && state != IDLE) ||
                         (p_left && !clr_left && state != LOCK && state != IDLE);
            p_right   <= (move_right && state != IDLE) ||
                         (p_right && !clr_right && state != LOCK && state != IDLE);
            p_fall    <= fall_wrap ||
                         (p_fall && !clr_fall && state != LOCK && state != IDLE);
            drop_mode <= (drop && state != IDLE) ||
                         (drop_mode && state != LOCK && state != IDLE);
        end
    end

endmodule
